// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU data-memory path.
//   MEMC_BYTE / MEMC_HALF   : access-size encoding carried on the memc signal
//   WMEM_READ / WMEM_WRITE  : direction encoding carried on the wmem signal
//   dmem_state_e            : state set of the data-memory responder FSM
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic MEMC_BYTE  = 1'b0;
    localparam logic MEMC_HALF  = 1'b1;

    localparam logic WMEM_READ  = 1'b0;
    localparam logic WMEM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } dmem_state_e;

endpackage

// File: rtl/dmem_byte_ram.sv
// ----------------------------------------------------------------------------
// dmem_byte_ram
// Byte-wide single-port storage array. Reads are combinational, writes
// happen on the rising clock edge. The array has no reset; its contents
// survive a reset of the surrounding logic.
//
// Parameters
//   DEPTH : number of bytes (power of two, >= 2)
// Ports
//   clk   : clock
//   we    : write enable for this cycle
//   addr  : byte address
//   wdata : byte to store when we is high
//   rdata : byte currently held at addr
// ----------------------------------------------------------------------------
module dmem_byte_ram #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder: accepts one byte or halfword load/store request at a
// time over a valid/ready handshake, performs it one byte per cycle against a
// byte-wide RAM (low byte first, little-endian) and returns a single response
// held until the consumer takes it.
//
// Build option
//   DMEM_MISALIGN_EN : when defined, odd-address halfword accesses are
//                      performed (the high byte wraps modulo DEPTH); when
//                      undefined they are rejected with rsp_err and no write.
//
// Parameters
//   DEPTH     : byte capacity, power of two, 2..65536
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset (memory contents are kept)
//   req_valid : request offered
//   req_ready : block is idle and will accept a request
//   req_addr  : byte address
//   wmem      : 0 = read, 1 = write
//   memc      : 0 = byte, 1 = halfword
//   wdata     : store data (byte uses [7:0], halfword low byte first)
//   rsp_valid : response pending
//   rsp_ready : consumer takes the response
//   rdata     : load result (byte loads sign-extended), 0 for writes/errors
//   rsp_err   : out-of-range address or disallowed misaligned halfword
// ----------------------------------------------------------------------------
module dmem_responder
    import cpu_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        wmem,
    input  logic        memc,
    input  logic [15:0] wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rdata,
    output logic        rsp_err
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [15:0] ADDR_MASK = 16'(DEPTH - 1);

    dmem_state_e   state;

    // Latched request fields; these are pure data and carry no reset.
    logic [AW-1:0] addr_q;
    logic          wmem_q;
    logic          memc_q;
    logic [15:0]   wdata_q;
    logic [7:0]    lo_byte;

    logic          accept;
    logic          range_err;
    logic          align_err;
    logic          req_err;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;

    function automatic logic signed [15:0] sext_byte(input logic signed [7:0] b);
        logic signed [15:0] r;
        r = b;
        return r;
    endfunction

    // req_ready is a registered copy of (state == IDLE).
    assign accept    = req_valid && req_ready;

    // Any address bit at or above log2(DEPTH) puts the access out of range.
    assign range_err = |(req_addr & ~ADDR_MASK);

`ifdef DMEM_MISALIGN_EN
    assign align_err = 1'b0;
`else
    assign align_err = (memc == MEMC_HALF) && req_addr[0];
`endif

    assign req_err   = range_err || align_err;

    // HI addresses the following byte; the AW-bit add wraps DEPTH-1 to 0.
    assign ram_addr  = (state == HI) ? addr_q + AW'(1) : addr_q;
    assign ram_we    = (wmem_q == WMEM_WRITE) && ((state == LO) || (state == HI));
    assign ram_wdata = (state == HI) ? wdata_q[15:8] : wdata_q[7:0];

    dmem_byte_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Request capture and low-byte holding register
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr[AW-1:0];
            wmem_q  <= wmem;
            memc_q  <= memc;
            wdata_q <= wdata;
        end
        if (state == LO) begin
            lo_byte <= ram_rdata;
        end
    end

    // Control FSM with registered handshake and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rdata     <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (req_err) begin
                            // Rejected requests never touch the array.
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rdata     <= '0;
                        end else begin
                            state <= LO;
                        end
                    end
                end
                LO: begin
                    if (memc_q == MEMC_HALF) begin
                        state <= HI;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rdata     <= (wmem_q == WMEM_WRITE) ? 16'd0 : 16'(sext_byte(ram_rdata));
                    end
                end
                HI: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rdata     <= (wmem_q == WMEM_WRITE) ? 16'd0 : {ram_rdata, lo_byte};
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rdata     <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the byte capacity of the memory; it is a power of two, at most 65536.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; one clock, reset is asynchronous and active-low.
REQ-004 The block SHALL have port req_valid, input, 1, meaning a request is offered.
REQ-005 The block SHALL have port req_ready, output, 1, meaning the block can accept a request this cycle.
REQ-006 The block SHALL have port req_addr, input, 16, the byte address.
REQ-007 The block SHALL have port wmem, input, 1, with 0 = read and 1 = write.
REQ-008 The block SHALL have port memc, input, 1, with 0 = byte and 1 = halfword.
REQ-009 The block SHALL have port wdata, input, 16, the store data.
REQ-010 The block SHALL have port rsp_valid, output, 1, meaning a response is pending.
REQ-011 The block SHALL have port rsp_ready, input, 1, meaning the consumer takes the response.
REQ-012 The block SHALL have port rdata, output, 16, the load result; it is 0 for writes and errors.
REQ-013 The block SHALL have port rsp_err, output, 1, meaning the request failed: out-of-range address, or misaligned halfword when the feature is disabled.

Function
REQ-014 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; req_addr, wmem, memc and wdata are latched at that edge.
REQ-015 req_ready SHALL be 1 only in state IDLE.
REQ-016 The state machine SHALL have states IDLE, LO, HI and RESP.
REQ-017 On accept, the next state SHALL be RESP with rsp_err=1 if there is an error; otherwise it SHALL be LO.
REQ-018 State LO SHALL access the byte at the latched address, then go to HI for a halfword or to RESP for a byte.
REQ-019 State HI SHALL access the byte at (address+1) modulo DEPTH, then go to RESP.
REQ-020 State RESP SHALL hold rsp_valid=1, with rdata and rsp_err stable, until rsp_ready=1; it then returns to IDLE.
REQ-021 Latency from the accept edge to rsp_valid high SHALL be 2 edges for a byte access, 3 edges for a halfword access and 1 edge for an error.
REQ-022 Byte order SHALL be little-endian: the low byte is at the address and the high byte is at address+1.
REQ-023 A byte write SHALL store wdata[7:0]; a halfword write SHALL store wdata[7:0] then wdata[15:8].
REQ-024 A byte read SHALL return the byte sign-extended to 16 bits; a halfword read SHALL return {byte@addr+1, byte@addr}.
REQ-025 Any req_addr bit at or above log2(DEPTH) set SHALL cause an error, and no memory write occurs.
REQ-026 A halfword at address DEPTH-1 SHALL wrap to byte 0 for its high byte when misaligned access is enabled.
REQ-027 req_valid asserted while not in IDLE SHALL be ignored, with no side effect.
REQ-028 rsp_ready asserted while not in RESP SHALL be ignored.

Reset
REQ-029 Asserting rst_n low SHALL immediately force state IDLE, req_ready=1, rsp_valid=0, rdata=0 and rsp_err=0.
REQ-030 Memory contents SHALL NOT be cleared by reset.
REQ-031 Reset during HI of a halfword write SHALL leave the low byte written and the high byte unwritten, and no response is issued.

Configuration
REQ-032 Macro DMEM_MISALIGN_EN defined SHALL allow odd-address halfword accesses, performed as LO then HI per REQ-018 and REQ-019.
REQ-033 Macro DMEM_MISALIGN_EN undefined SHALL make an odd-address halfword an error per REQ-017, with no memory write.

Structure
REQ-034 Shared package cpu_pkg SHALL hold the MEMC_BYTE and MEMC_HALF constants, the WMEM_READ and WMEM_WRITE constants, and the dmem state enum.
REQ-035 Sub-module dmem_byte_ram SHALL implement the byte-wide single-port array with combinational read and clocked write; dmem_responder instantiates it once.

Verification
REQ-036 Byte write to 0x0010 with wdata=0x1280, then byte read of 0x0010 SHALL give rdata=0xFF80, with rsp_valid high 2 edges after accept.
REQ-037 Halfword write to 0x0020 with wdata=0xBEEF, then halfword read of 0x0020 SHALL give 0xBEEF, and byte reads SHALL give 0xFFEF at 0x0020 and 0xFFBE at 0x0021.
REQ-038 Halfword write to 0x00FF with wdata=0x1234 and DEPTH=256 SHALL, with DMEM_MISALIGN_EN, give 0x0034 at byte 0x00FF and 0x0012 at byte 0x0000; without the macro it SHALL give rsp_err=1 1 edge after accept and leave memory unchanged.
REQ-039 A read of address 0x0100 with DEPTH=256 SHALL give rsp_err=1 and rdata=0.
REQ-040 Holding rsp_ready=0 for 5 cycles in RESP SHALL keep rsp_valid, rdata and req_ready=0 stable, and a req_valid pulse during that time SHALL cause no access.
REQ-041 rst_n pulsed low during HI of a halfword write of 0xAABB to 0x0040 SHALL give rsp_valid=0 at once and req_ready=1, with byte 0x0040 = 0xBB and byte 0x0041 unchanged.
